// File: rtl/axis_upsizer_pkg.sv
// Shared AXI-Stream width defaults and parameter legality helpers.
package axis_upsizer_pkg;

   localparam int unsigned AXIS_S_DATA_WIDTH = 8;
   localparam int unsigned AXIS_RATIO        = 4;
   localparam int unsigned AXIS_USER_WIDTH   = 1;
   localparam int unsigned AXIS_RATIO_MIN    = 2;
   localparam int unsigned AXIS_RATIO_MAX    = 16;

   // True when the packing ratio is within the supported range.
   function automatic bit axis_ratio_legal(input int unsigned ratio);
      return (ratio >= AXIS_RATIO_MIN) && (ratio <= AXIS_RATIO_MAX);
   endfunction

endpackage

// File: rtl/axis_upsizer_if.sv
// Narrow input stream and wide output stream of the upsizer, bundled together.
// The slave modport is the upsizer's view; master is the surrounding logic.
interface axis_upsizer_if
   import axis_upsizer_pkg::*;
#(
   parameter int unsigned S_DATA_WIDTH = AXIS_S_DATA_WIDTH,
   parameter int unsigned RATIO        = AXIS_RATIO,
   parameter int unsigned USER_WIDTH   = AXIS_USER_WIDTH
);

   localparam int unsigned M_DATA_WIDTH = S_DATA_WIDTH * RATIO;
   localparam int unsigned KEEP_WIDTH   = RATIO;

   logic [S_DATA_WIDTH-1:0] s_axis_tdata;
   logic                    s_axis_tvalid;
   logic                    s_axis_tready;
   logic                    s_axis_tlast;
   logic [USER_WIDTH-1:0]   s_axis_tuser;

   logic [M_DATA_WIDTH-1:0] m_axis_tdata;
   logic [KEEP_WIDTH-1:0]   m_axis_tkeep;
   logic                    m_axis_tvalid;
   logic                    m_axis_tready;
   logic                    m_axis_tlast;
   logic [USER_WIDTH-1:0]   m_axis_tuser;

   modport slave (
      input  s_axis_tdata, s_axis_tvalid, s_axis_tlast, s_axis_tuser,
      output s_axis_tready,
      output m_axis_tdata, m_axis_tkeep, m_axis_tvalid, m_axis_tlast, m_axis_tuser,
      input  m_axis_tready
   );

   modport master (
      output s_axis_tdata, s_axis_tvalid, s_axis_tlast, s_axis_tuser,
      input  s_axis_tready,
      input  m_axis_tdata, m_axis_tkeep, m_axis_tvalid, m_axis_tlast, m_axis_tuser,
      output m_axis_tready
   );

endinterface

// File: rtl/axis_upsizer.sv
// Packs RATIO narrow AXI-Stream beats into one wide beat, lane 0 first.
// A packet end closes the word early with unfilled lanes zeroed and unkept.
module axis_upsizer
   import axis_upsizer_pkg::*;
#(
   parameter int unsigned S_DATA_WIDTH = AXIS_S_DATA_WIDTH,
   parameter int unsigned RATIO        = AXIS_RATIO,
   parameter int unsigned USER_WIDTH   = AXIS_USER_WIDTH
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           clr,
   axis_upsizer_if.slave  bus
);

   localparam int unsigned M_DATA_WIDTH = S_DATA_WIDTH * RATIO;
   localparam int unsigned KEEP_WIDTH   = RATIO;
   localparam int unsigned CNT_W        = $clog2(RATIO);
   localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(RATIO - 1);

   // Reject unsupported ratios at elaboration.
   if (!axis_ratio_legal(RATIO)) begin : g_bad_ratio
      $error("axis_upsizer: RATIO must be within 2..16");
   end

   logic [CNT_W-1:0]        lane_cnt_q,  lane_cnt_d;
   logic [USER_WIDTH-1:0]   user_acc_q,  user_acc_d;
   logic [M_DATA_WIDTH-1:0] acc_q,       acc_d;
   logic                    m_tvalid_q,  m_tvalid_d;
   logic [KEEP_WIDTH-1:0]   m_tkeep_q,   m_tkeep_d;
   logic [M_DATA_WIDTH-1:0] m_tdata_q,   m_tdata_d;
   logic                    m_tlast_q,   m_tlast_d;
   logic [USER_WIDTH-1:0]   m_tuser_q,   m_tuser_d;

   logic                    s_ready_c;
   logic                    accept_c;
   logic                    complete_c;
   logic                    m_fire_c;
   logic [M_DATA_WIDTH-1:0] word_c;
   logic [KEEP_WIDTH-1:0]   keep_c;

   // Ready only depends on the output register state; reset forces it high.
   assign s_ready_c = rst || !m_tvalid_q || bus.m_axis_tready;

   // Handshake decode, word assembly and next-state for all registers.
   always_comb begin
      accept_c   = 1'b0;
      complete_c = 1'b0;
      m_fire_c   = 1'b0;
      word_c     = '0;
      keep_c     = '0;
      acc_d      = acc_q;
      lane_cnt_d = lane_cnt_q;
      user_acc_d = user_acc_q;
      m_tvalid_d = m_tvalid_q;
      m_tkeep_d  = m_tkeep_q;
      m_tdata_d  = m_tdata_q;
      m_tlast_d  = m_tlast_q;
      m_tuser_d  = m_tuser_q;

      // A beat arriving together with clr is dropped along with the partial word.
      accept_c   = bus.s_axis_tvalid && s_ready_c && !clr;
      // Explicit compare against RATIO-1 so non power-of-two ratios close correctly.
      complete_c = accept_c && ((lane_cnt_q == LAST_LANE) || bus.s_axis_tlast);
      m_fire_c   = m_tvalid_q && bus.m_axis_tready;

      // Lanes below the counter come from the accumulator, the current lane from
      // the input, and lanes above stay zero so stale data never leaks out.
      for (int unsigned i = 0; i < RATIO; i++) begin
         if (CNT_W'(i) < lane_cnt_q) begin
            word_c[i*S_DATA_WIDTH +: S_DATA_WIDTH] = acc_q[i*S_DATA_WIDTH +: S_DATA_WIDTH];
         end
         if (CNT_W'(i) == lane_cnt_q) begin
            word_c[i*S_DATA_WIDTH +: S_DATA_WIDTH] = bus.s_axis_tdata;
            if (accept_c) begin
               acc_d[i*S_DATA_WIDTH +: S_DATA_WIDTH] = bus.s_axis_tdata;
            end
         end
         keep_c[i] = (CNT_W'(i) <= lane_cnt_q);
      end

      if (clr) begin
         lane_cnt_d = '0;
         user_acc_d = '0;
      end else if (complete_c) begin
         lane_cnt_d = '0;
         user_acc_d = '0;
      end else if (accept_c) begin
         lane_cnt_d = lane_cnt_q + CNT_W'(1);
         user_acc_d = user_acc_q | bus.s_axis_tuser;
      end

      // A completing word reloads the output even while the old one drains.
      if (complete_c) begin
         m_tvalid_d = 1'b1;
         m_tkeep_d  = keep_c;
         m_tdata_d  = word_c;
         m_tlast_d  = bus.s_axis_tlast;
         m_tuser_d  = user_acc_q | bus.s_axis_tuser;
      end else if (m_fire_c) begin
         m_tvalid_d = 1'b0;
         m_tkeep_d  = '0;
      end
   end

   // Control registers, cleared by reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         lane_cnt_q <= '0;
         user_acc_q <= '0;
         m_tvalid_q <= 1'b0;
         m_tkeep_q  <= '0;
      end else begin
         lane_cnt_q <= lane_cnt_d;
         user_acc_q <= user_acc_d;
         m_tvalid_q <= m_tvalid_d;
         m_tkeep_q  <= m_tkeep_d;
      end
   end

   // Datapath registers, no reset needed.
   always_ff @(posedge clk) begin
      acc_q     <= acc_d;
      m_tdata_q <= m_tdata_d;
      m_tlast_q <= m_tlast_d;
      m_tuser_q <= m_tuser_d;
   end

   assign bus.s_axis_tready = s_ready_c;
   assign bus.m_axis_tvalid = m_tvalid_q;
   assign bus.m_axis_tkeep  = m_tkeep_q;
   assign bus.m_axis_tdata  = m_tdata_q;
   assign bus.m_axis_tlast  = m_tlast_q;
   assign bus.m_axis_tuser  = m_tuser_q;

endmodule

// File: tb/tb_axis_upsizer.sv
// Directed bench for axis_upsizer with RATIO=4, 8-bit input words.
module tb_axis_upsizer;

   localparam int unsigned SW = 8;
   localparam int unsigned R  = 4;
   localparam int unsigned UW = 1;

   logic clk;
   logic rst;
   logic clr;
   int   tests = 0;
   int   fails = 0;

   axis_upsizer_if #(.S_DATA_WIDTH(SW), .RATIO(R), .USER_WIDTH(UW)) bus ();

   axis_upsizer #(.S_DATA_WIDTH(SW), .RATIO(R), .USER_WIDTH(UW)) u_dut (
      .clk (clk),
      .rst (rst),
      .clr (clr),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One clock edge; returns at the following falling edge.
   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      tests++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic idle();
      bus.s_axis_tvalid = 1'b0;
      bus.s_axis_tdata  = '0;
      bus.s_axis_tlast  = 1'b0;
      bus.s_axis_tuser  = '0;
   endtask

   // Present one beat, confirm it will be taken, and clock it in.
   task automatic beat(input logic [7:0] d, input logic l, input logic u, input string tag);
      bus.s_axis_tvalid = 1'b1;
      bus.s_axis_tdata  = d;
      bus.s_axis_tlast  = l;
      bus.s_axis_tuser  = u;
      #1;
      check(tag, 64'(bus.s_axis_tready), 64'(1));
      tick();
   endtask

   task automatic check_word(input string tag, input logic [31:0] data, input logic [3:0] keep,
                             input logic last, input logic user);
      check({tag, ".valid"}, 64'(bus.m_axis_tvalid), 64'(1));
      check({tag, ".data"},  64'(bus.m_axis_tdata),  64'(data));
      check({tag, ".keep"},  64'(bus.m_axis_tkeep),  64'(keep));
      check({tag, ".last"},  64'(bus.m_axis_tlast),  64'(last));
      check({tag, ".user"},  64'(bus.m_axis_tuser),  64'(user));
   endtask

   // Empty output register: valid low, keep zero.
   task automatic check_empty(input string tag);
      check({tag, ".valid"}, 64'(bus.m_axis_tvalid), 64'(0));
      check({tag, ".keep"},  64'(bus.m_axis_tkeep),  64'(0));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] exp_w;

      rst = 1'b1;
      clr = 1'b0;
      bus.m_axis_tready = 1'b0;
      idle();

      // Reset state
      tick();
      tick();
      check_empty("reset");
      check("reset.s_ready", 64'(bus.s_axis_tready), 64'(1));
      rst = 1'b0;
      tick();

      // Full word, one cycle after the 4th beat
      bus.m_axis_tready = 1'b1;
      beat(8'h11, 1'b0, 1'b0, "full.rdy");
      check("full.no_early_valid", 64'(bus.m_axis_tvalid), 64'(0));
      beat(8'h22, 1'b0, 1'b0, "full.rdy");
      beat(8'h33, 1'b0, 1'b0, "full.rdy");
      beat(8'h44, 1'b0, 1'b0, "full.rdy");
      check_word("full", 32'h4433_2211, 4'hF, 1'b0, 1'b0);
      idle();
      tick();
      check_empty("full.drained");

      // Short packet, then single-beat packets back to back with no bubble
      beat(8'hAA, 1'b0, 1'b0, "short.rdy");
      beat(8'hBB, 1'b1, 1'b0, "short.rdy");
      check_word("short", 32'h0000_BBAA, 4'h3, 1'b1, 1'b0);
      beat(8'h61, 1'b1, 1'b0, "single.rdy");
      check_word("single0", 32'h0000_0061, 4'h1, 1'b1, 1'b0);
      beat(8'h62, 1'b1, 1'b0, "single.rdy");
      check_word("single1", 32'h0000_0062, 4'h1, 1'b1, 1'b0);
      beat(8'h63, 1'b1, 1'b0, "single.rdy");
      check_word("single2", 32'h0000_0063, 4'h1, 1'b1, 1'b0);
      idle();
      tick();
      check_empty("single.drained");

      // tuser OR across a word, cleared for the next word
      beat(8'h01, 1'b0, 1'b0, "user.rdy");
      beat(8'h02, 1'b0, 1'b1, "user.rdy");
      beat(8'h03, 1'b0, 1'b0, "user.rdy");
      beat(8'h04, 1'b0, 1'b0, "user.rdy");
      check_word("user_set", 32'h0403_0201, 4'hF, 1'b0, 1'b1);
      beat(8'h05, 1'b0, 1'b0, "user.rdy");
      beat(8'h06, 1'b0, 1'b0, "user.rdy");
      beat(8'h07, 1'b0, 1'b0, "user.rdy");
      beat(8'h08, 1'b1, 1'b0, "user.rdy");
      check_word("user_clr", 32'h0807_0605, 4'hF, 1'b1, 1'b0);
      idle();
      tick();

      // Backpressure: pending word held stable for 5 cycles
      bus.m_axis_tready = 1'b0;
      beat(8'hA1, 1'b0, 1'b0, "bp.rdy");
      beat(8'hA2, 1'b0, 1'b0, "bp.rdy");
      beat(8'hA3, 1'b0, 1'b0, "bp.rdy");
      beat(8'hA4, 1'b0, 1'b0, "bp.rdy");
      idle();
      for (int c = 0; c < 5; c++) begin
         check("bp.s_ready", 64'(bus.s_axis_tready), 64'(0));
         check_word("bp.hold", 32'hA4A3_A2A1, 4'hF, 1'b0, 1'b0);
         tick();
      end
      bus.m_axis_tready = 1'b1;
      #1;
      check("bp.release_ready", 64'(bus.s_axis_tready), 64'(1));

      // Sustained stream of 64 beats, one per cycle
      for (int k = 0; k < 64; k++) begin
         beat(8'(k), 1'b0, 1'b0, "stream.rdy");
         check("stream.valid", 64'(bus.m_axis_tvalid), 64'((k % 4) == 3));
         if ((k % 4) == 3) begin
            exp_w = {8'(k), 8'(k - 1), 8'(k - 2), 8'(k - 3)};
            check("stream.data", 64'(bus.m_axis_tdata), 64'(exp_w));
         end
      end
      idle();
      tick();
      check_empty("stream.drained");

      // clr drops a partial word and the beat presented with it
      beat(8'hC1, 1'b0, 1'b0, "clr.rdy");
      beat(8'hC2, 1'b0, 1'b0, "clr.rdy");
      clr = 1'b1;
      bus.s_axis_tvalid = 1'b1;
      bus.s_axis_tdata  = 8'hEE;
      tick();
      clr = 1'b0;
      check_empty("clr.no_output");
      bus.m_axis_tready = 1'b0;
      beat(8'h01, 1'b0, 1'b0, "clr.rdy");
      beat(8'h02, 1'b0, 1'b0, "clr.rdy");
      beat(8'h03, 1'b0, 1'b0, "clr.rdy");
      beat(8'h04, 1'b0, 1'b0, "clr.rdy");
      check_word("clr.word", 32'h0403_0201, 4'hF, 1'b0, 1'b0);
      // clr with a pending output word leaves it intact
      idle();
      clr = 1'b1;
      tick();
      clr = 1'b0;
      check_word("clr.pending", 32'h0403_0201, 4'hF, 1'b0, 1'b0);
      bus.m_axis_tready = 1'b1;
      tick();
      check_empty("clr.drained");

      // Reset mid-packet drops the partial word
      beat(8'h71, 1'b0, 1'b0, "rstmid.rdy");
      beat(8'h72, 1'b0, 1'b0, "rstmid.rdy");
      beat(8'h73, 1'b0, 1'b0, "rstmid.rdy");
      rst = 1'b1;
      bus.s_axis_tvalid = 1'b1;
      bus.s_axis_tdata  = 8'hEE;
      tick();
      check_empty("rstmid");
      check("rstmid.s_ready", 64'(bus.s_axis_tready), 64'(1));
      rst = 1'b0;
      idle();
      tick();
      beat(8'h81, 1'b0, 1'b0, "rstmid.rdy");
      beat(8'h82, 1'b0, 1'b0, "rstmid.rdy");
      beat(8'h83, 1'b0, 1'b0, "rstmid.rdy");
      beat(8'h84, 1'b0, 1'b0, "rstmid.rdy");
      check_word("rstmid.after", 32'h8483_8281, 4'hF, 1'b0, 1'b0);
      idle();
      tick();

      // Reset drops a pending output word; ready is forced high during reset
      bus.m_axis_tready = 1'b0;
      beat(8'h91, 1'b0, 1'b0, "rstpend.rdy");
      beat(8'h92, 1'b0, 1'b0, "rstpend.rdy");
      beat(8'h93, 1'b0, 1'b0, "rstpend.rdy");
      beat(8'h94, 1'b0, 1'b0, "rstpend.rdy");
      check_word("rstpend.before", 32'h9493_9291, 4'hF, 1'b0, 1'b0);
      idle();
      rst = 1'b1;
      #1;
      check("rstpend.s_ready_in_rst", 64'(bus.s_axis_tready), 64'(1));
      tick();
      check_empty("rstpend");
      rst = 1'b0;
      tick();
      check_empty("rstpend.after");
      check("rstpend.s_ready_after", 64'(bus.s_axis_tready), 64'(1));

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
